// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin tie-break
// and a bus watchdog that turns a hung slave access into ERR for the owner.
module wb_arbiter2 #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic          CLK_I,
  input  logic          RST_I,

  input  logic          M0_CYC_I,
  input  logic          M0_STB_I,
  input  logic          M0_WE_I,
  input  logic [AW-1:0] M0_ADR_I,
  input  logic [31:0]   M0_DAT_I,
  input  logic [3:0]    M0_SEL_I,
  output logic [31:0]   M0_DAT_O,
  output logic          M0_ACK_O,
  output logic          M0_ERR_O,

  input  logic          M1_CYC_I,
  input  logic          M1_STB_I,
  input  logic          M1_WE_I,
  input  logic [AW-1:0] M1_ADR_I,
  input  logic [31:0]   M1_DAT_I,
  input  logic [3:0]    M1_SEL_I,
  output logic [31:0]   M1_DAT_O,
  output logic          M1_ACK_O,
  output logic          M1_ERR_O,

  output logic          S_CYC_O,
  output logic          S_STB_O,
  output logic          S_WE_O,
  output logic [AW-1:0] S_ADR_O,
  output logic [31:0]   S_DAT_O,
  output logic [3:0]    S_SEL_O,
  input  logic [31:0]   S_DAT_I,
  input  logic          S_ACK_I,
  input  logic          S_ERR_I,

  output logic [1:0]    GNT_O
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic          last;
  logic [TW-1:0] wd_count;
  logic          own0;
  logic          own1;
  logic          own_stb;
  logic          wd_fire;
  logic          wd_clear;

  assign own0    = (state == OWN0);
  assign own1    = (state == OWN1);
  assign own_stb = (own0 & M0_STB_I) | (own1 & M1_STB_I);
  assign wd_fire = (own0 | own1) && (wd_count == TW'(TIMEOUT));

  // On a tie the master that did not own the bus last wins; owners must
  // always pass through IDLE before the other master can be granted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (M0_CYC_I && M1_CYC_I)
          state_next = last ? OWN0 : OWN1;
        else if (M0_CYC_I)
          state_next = OWN0;
        else if (M1_CYC_I)
          state_next = OWN1;
      end
      OWN0:    if (!M0_CYC_I) state_next = IDLE;
      OWN1:    if (!M1_CYC_I) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == OWN0)
        last <= 1'b0;
      else if (state == IDLE && state_next == OWN1)
        last <= 1'b1;
    end
  end

  // Watchdog restarts whenever the access terminates, the strobe drops or
  // ownership ends; clearing on fire keeps it from ever passing TIMEOUT.
  assign wd_clear = !(own0 | own1) || !own_stb || S_ACK_I || S_ERR_I ||
                    wd_fire || (state_next == IDLE);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I)
      wd_count <= '0;
    else if (wd_clear)
      wd_count <= '0;
    else if (wd_count < TW'(TIMEOUT))
      wd_count <= wd_count + 1'b1;
  end

  assign S_CYC_O = (own0 & M0_CYC_I) | (own1 & M1_CYC_I);
  assign S_STB_O = own_stb & ~wd_fire;
  assign S_WE_O  = own1 ? M1_WE_I  : M0_WE_I;
  assign S_ADR_O = own1 ? M1_ADR_I : M0_ADR_I;
  assign S_DAT_O = own1 ? M1_DAT_I : M0_DAT_I;
  assign S_SEL_O = own1 ? M1_SEL_I : M0_SEL_I;

  assign M0_DAT_O = own0 ? S_DAT_I : 32'h0;
  assign M0_ACK_O = own0 & S_ACK_I & M0_STB_I;
  assign M0_ERR_O = own0 & ((S_ERR_I & M0_STB_I) | wd_fire);

  assign M1_DAT_O = own1 ? S_DAT_I : 32'h0;
  assign M1_ACK_O = own1 & S_ACK_I & M1_STB_I;
  assign M1_ERR_O = own1 & ((S_ERR_I & M1_STB_I) | wd_fire);

  assign GNT_O = {own1, own0};

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: grant order, idle gap, burst hold-off,
// watchdog timeout, slave error routing and asynchronous reset.
module tb_wb_arbiter2;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        M0_CYC_I, M0_STB_I, M0_WE_I;
  logic [31:0] M0_ADR_I, M0_DAT_I;
  logic [3:0]  M0_SEL_I;
  logic [31:0] M0_DAT_O;
  logic        M0_ACK_O, M0_ERR_O;
  logic        M1_CYC_I, M1_STB_I, M1_WE_I;
  logic [31:0] M1_ADR_I, M1_DAT_I;
  logic [3:0]  M1_SEL_I;
  logic [31:0] M1_DAT_O;
  logic        M1_ACK_O, M1_ERR_O;
  logic        S_CYC_O, S_STB_O, S_WE_O;
  logic [31:0] S_ADR_O, S_DAT_O;
  logic [3:0]  S_SEL_O;
  logic [31:0] S_DAT_I;
  logic        S_ACK_I, S_ERR_I;
  logic [1:0]  GNT_O;

  logic        slave_hang = 1'b0;
  logic        slave_err  = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  logic [31:0] wr_adr   = '0;
  logic [31:0] wr_dat   = '0;
  logic [3:0]  wr_sel   = '0;

  wb_arbiter2 #(.AW(32), .TIMEOUT(16), .TW(5)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .M0_CYC_I(M0_CYC_I), .M0_STB_I(M0_STB_I), .M0_WE_I(M0_WE_I),
    .M0_ADR_I(M0_ADR_I), .M0_DAT_I(M0_DAT_I), .M0_SEL_I(M0_SEL_I),
    .M0_DAT_O(M0_DAT_O), .M0_ACK_O(M0_ACK_O), .M0_ERR_O(M0_ERR_O),
    .M1_CYC_I(M1_CYC_I), .M1_STB_I(M1_STB_I), .M1_WE_I(M1_WE_I),
    .M1_ADR_I(M1_ADR_I), .M1_DAT_I(M1_DAT_I), .M1_SEL_I(M1_SEL_I),
    .M1_DAT_O(M1_DAT_O), .M1_ACK_O(M1_ACK_O), .M1_ERR_O(M1_ERR_O),
    .S_CYC_O(S_CYC_O), .S_STB_O(S_STB_O), .S_WE_O(S_WE_O),
    .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_SEL_O(S_SEL_O),
    .S_DAT_I(S_DAT_I), .S_ACK_I(S_ACK_I), .S_ERR_I(S_ERR_I),
    .GNT_O(GNT_O)
  );

  always #5 CLK_I = ~CLK_I;

  // Zero-wait slave: read data is a fixed pattern of the address.
  assign S_DAT_I = {16'hD000, S_ADR_O[15:0]};
  assign S_ACK_I = S_CYC_O & S_STB_O & ~slave_hang & ~slave_err;
  assign S_ERR_I = S_CYC_O & S_STB_O & slave_err;

  always @(posedge CLK_I) begin
    if (S_CYC_O && S_STB_O && S_ACK_I && S_WE_O) begin
      wr_cnt <= wr_cnt + 1;
      wr_adr <= S_ADR_O;
      wr_dat <= S_DAT_O;
      wr_sel <= S_SEL_O;
    end
  end

  always @(negedge CLK_I) begin
    n_checks++;
    if ((M0_ACK_O && M0_ERR_O) || (M1_ACK_O && M1_ERR_O)) begin
      n_fail++;
      $display("[TB] FAIL ack_err_excl: got m0 %b%b m1 %b%b, required ACK and ERR not both 1",
               M0_ACK_O, M0_ERR_O, M1_ACK_O, M1_ERR_O);
    end
  end

  task automatic to_drive;
    @(posedge CLK_I);
    #1;
  endtask

  task automatic to_sample;
    @(negedge CLK_I);
  endtask

  task automatic idle_masters;
    M0_CYC_I = 0; M0_STB_I = 0; M0_WE_I = 0; M0_ADR_I = '0; M0_DAT_I = '0; M0_SEL_I = '0;
    M1_CYC_I = 0; M1_STB_I = 0; M1_WE_I = 0; M1_ADR_I = '0; M1_DAT_I = '0; M1_SEL_I = '0;
  endtask

  task automatic go_idle;
    to_drive;
    idle_masters;
    to_drive;
    to_drive;
  endtask

  task automatic test_reset;
    M0_CYC_I = 1; M0_STB_I = 1; M1_CYC_I = 1; M1_STB_I = 1;
    to_sample;
    n_checks++; if (GNT_O !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_gnt: got %b want 00", GNT_O); end
    n_checks++; if (S_CYC_O !== 1'b0 || S_STB_O !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_slave: got cyc %b stb %b want 0 0", S_CYC_O, S_STB_O); end
    n_checks++; if ({M0_ACK_O, M0_ERR_O, M1_ACK_O, M1_ERR_O} !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_term: got %b%b%b%b want 0000", M0_ACK_O, M0_ERR_O, M1_ACK_O, M1_ERR_O); end
    to_drive;
    idle_masters;
    RST_I = 0;
    to_sample;
    n_checks++; if (GNT_O !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_release_gnt: got %b want 00", GNT_O); end
  endtask

  task automatic test_m0_write;
    int wr_before;
    wr_before = wr_cnt;
    to_drive;
    M0_CYC_I = 1; M0_STB_I = 1; M0_WE_I = 1; M0_ADR_I = 32'h10; M0_DAT_I = 32'hA5A5A5A5; M0_SEL_I = 4'hF;
    to_sample;
    n_checks++; if (GNT_O !== 2'b00 || S_CYC_O !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_req_cycle: got gnt %b cyc %b want 00 0", GNT_O, S_CYC_O); end
    to_sample;
    n_checks++; if (GNT_O !== 2'b01) begin n_fail++; $display("[TB] FAIL wr_gnt: got %b want 01", GNT_O); end
    n_checks++; if (S_CYC_O !== 1'b1 || S_STB_O !== 1'b1 || S_WE_O !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_slave_ctl: got %b%b%b want 111", S_CYC_O, S_STB_O, S_WE_O); end
    n_checks++; if (S_ADR_O !== 32'h10 || S_DAT_O !== 32'hA5A5A5A5 || S_SEL_O !== 4'hF) begin n_fail++; $display("[TB] FAIL wr_slave_bus: got %h %h %h want 00000010 a5a5a5a5 f", S_ADR_O, S_DAT_O, S_SEL_O); end
    n_checks++; if (M0_ACK_O !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_ack: got %b want 1", M0_ACK_O); end
    to_drive;
    idle_masters;
    to_sample;
    n_checks++; if (wr_cnt !== wr_before + 1 || wr_adr !== 32'h10 || wr_dat !== 32'hA5A5A5A5 || wr_sel !== 4'hF) begin
      n_fail++; $display("[TB] FAIL wr_capture: got n=%0d %h %h %h want n=%0d 00000010 a5a5a5a5 f", wr_cnt - wr_before, wr_adr, wr_dat, wr_sel, 1);
    end
    n_checks++; if (M0_ACK_O !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_ack_drop: got %b want 0", M0_ACK_O); end
    to_sample;
    n_checks++; if (GNT_O !== 2'b00) begin n_fail++; $display("[TB] FAIL wr_back_idle: got %b want 00", GNT_O); end
  endtask

  task automatic test_tie;
    to_drive;
    RST_I = 1;
    to_drive;
    RST_I = 0;
    to_drive;
    M0_CYC_I = 1; M0_STB_I = 1; M0_ADR_I = 32'h20;
    M1_CYC_I = 1; M1_STB_I = 1; M1_ADR_I = 32'h40;
    to_sample;
    n_checks++; if (GNT_O !== 2'b00) begin n_fail++; $display("[TB] FAIL tie_req_cycle: got %b want 00", GNT_O); end
    to_sample;
    n_checks++; if (GNT_O !== 2'b01) begin n_fail++; $display("[TB] FAIL tie_first_m0: got %b want 01", GNT_O); end
    n_checks++; if (M0_ACK_O !== 1'b1 || M0_DAT_O !== 32'hD0000020) begin n_fail++; $display("[TB] FAIL tie_m0_read: got ack %b dat %h want 1 d0000020", M0_ACK_O, M0_DAT_O); end
    n_checks++; if (M1_ACK_O !== 1'b0 || M1_DAT_O !== 32'h0) begin n_fail++; $display("[TB] FAIL tie_m1_held: got ack %b dat %h want 0 00000000", M1_ACK_O, M1_DAT_O); end
    to_drive;
    M0_CYC_I = 0; M0_STB_I = 0;
    to_sample;
    to_sample;
    n_checks++; if (GNT_O !== 2'b00 || M1_ACK_O !== 1'b0) begin n_fail++; $display("[TB] FAIL tie_idle_gap: got gnt %b ack1 %b want 00 0", GNT_O, M1_ACK_O); end
    to_sample;
    n_checks++; if (GNT_O !== 2'b10) begin n_fail++; $display("[TB] FAIL tie_then_m1: got %b want 10", GNT_O); end
    n_checks++; if (M1_ACK_O !== 1'b1 || M1_DAT_O !== 32'hD0000040) begin n_fail++; $display("[TB] FAIL tie_m1_read: got ack %b dat %h want 1 d0000040", M1_ACK_O, M1_DAT_O); end
    to_drive;
    M1_CYC_I = 0; M1_STB_I = 0;
    to_drive;
    M0_CYC_I = 1; M0_STB_I = 1;
    M1_CYC_I = 1; M1_STB_I = 1;
    to_sample;
    to_sample;
    n_checks++; if (GNT_O !== 2'b01) begin n_fail++; $display("[TB] FAIL tie_second_m0: got %b want 01", GNT_O); end
    go_idle;
  endtask

  task automatic test_burst_hold;
    to_drive;
    M1_CYC_I = 1; M1_STB_I = 1; M1_WE_I = 0; M1_ADR_I = 32'h100;
    to_sample;
    for (int k = 0; k < 4; k++) begin
      to_sample;
      n_checks++; if (GNT_O !== 2'b10 || M1_ACK_O !== 1'b1) begin n_fail++; $display("[TB] FAIL burst_beat%0d: got gnt %b ack1 %b want 10 1", k, GNT_O, M1_ACK_O); end
      n_checks++; if (M1_DAT_O !== {16'hD000, 16'h0100 + 16'(4 * k)}) begin n_fail++; $display("[TB] FAIL burst_data%0d: got %h want %h", k, M1_DAT_O, {16'hD000, 16'h0100 + 16'(4 * k)}); end
      n_checks++; if (M0_ACK_O !== 1'b0 || M0_ERR_O !== 1'b0) begin n_fail++; $display("[TB] FAIL burst_m0_held%0d: got ack %b err %b want 0 0", k, M0_ACK_O, M0_ERR_O); end
      to_drive;
      if (k == 0) begin
        M0_CYC_I = 1; M0_STB_I = 1; M0_ADR_I = 32'h200;
      end
      if (k == 3) begin
        M1_CYC_I = 0; M1_STB_I = 0;
      end else begin
        M1_ADR_I = 32'h100 + 32'(4 * (k + 1));
      end
    end
    to_sample;
    n_checks++; if (M0_ACK_O !== 1'b0) begin n_fail++; $display("[TB] FAIL burst_release_c0: got ack0 %b want 0", M0_ACK_O); end
    to_sample;
    n_checks++; if (GNT_O !== 2'b00 || M0_ACK_O !== 1'b0) begin n_fail++; $display("[TB] FAIL burst_release_c1: got gnt %b ack0 %b want 00 0", GNT_O, M0_ACK_O); end
    to_sample;
    n_checks++; if (GNT_O !== 2'b01 || M0_ACK_O !== 1'b1) begin n_fail++; $display("[TB] FAIL burst_release_c2: got gnt %b ack0 %b want 01 1", GNT_O, M0_ACK_O); end
    go_idle;
  endtask

  task automatic test_watchdog;
    slave_hang = 1;
    to_drive;
    M0_CYC_I = 1; M0_STB_I = 1; M0_ADR_I = 32'h300;
    to_sample;
    for (int c = 1; c <= 16; c++) begin
      to_sample;
      n_checks++; if (M0_ERR_O !== 1'b0 || S_STB_O !== 1'b1 || M0_ACK_O !== 1'b0) begin
        n_fail++; $display("[TB] FAIL wd_wait_cycle%0d: got err %b stb %b ack %b want 0 1 0", c, M0_ERR_O, S_STB_O, M0_ACK_O);
      end
    end
    to_sample;
    n_checks++; if (M0_ERR_O !== 1'b1 || S_STB_O !== 1'b0 || M0_ACK_O !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_fire: got err %b stb %b ack %b want 1 0 0", M0_ERR_O, S_STB_O, M0_ACK_O); end
    n_checks++; if (M1_ERR_O !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_nonowner: got err1 %b want 0", M1_ERR_O); end
    to_sample;
    n_checks++; if (M0_ERR_O !== 1'b0 || S_STB_O !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_cleared: got err %b stb %b want 0 1", M0_ERR_O, S_STB_O); end
    go_idle;
    slave_hang = 0;
  endtask

  task automatic test_slave_err;
    slave_err = 1;
    to_drive;
    M1_CYC_I = 1; M1_STB_I = 1; M1_WE_I = 1; M1_ADR_I = 32'h400;
    to_drive;
    M0_CYC_I = 1; M0_STB_I = 1; M0_ADR_I = 32'h500;
    to_sample;
    n_checks++; if (GNT_O !== 2'b10 || M1_ERR_O !== 1'b1 || M1_ACK_O !== 1'b0) begin n_fail++; $display("[TB] FAIL serr_owner: got gnt %b err1 %b ack1 %b want 10 1 0", GNT_O, M1_ERR_O, M1_ACK_O); end
    n_checks++; if (M0_ERR_O !== 1'b0 || M0_ACK_O !== 1'b0) begin n_fail++; $display("[TB] FAIL serr_nonowner: got err0 %b ack0 %b want 0 0", M0_ERR_O, M0_ACK_O); end
    go_idle;
    slave_err = 0;
  endtask

  task automatic test_reset_mid_burst;
    to_drive;
    M0_CYC_I = 1; M0_STB_I = 1; M0_ADR_I = 32'h600;
    to_sample;
    to_sample;
    n_checks++; if (GNT_O !== 2'b01 || S_CYC_O !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_owned: got gnt %b cyc %b want 01 1", GNT_O, S_CYC_O); end
    #2;
    RST_I = 1;
    M1_CYC_I = 1; M1_STB_I = 1; M1_ADR_I = 32'h700;
    #1;
    n_checks++; if (GNT_O !== 2'b00 || S_CYC_O !== 1'b0 || S_STB_O !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_async: got gnt %b cyc %b stb %b want 00 0 0", GNT_O, S_CYC_O, S_STB_O); end
    n_checks++; if (M0_ACK_O !== 1'b0 || M0_ERR_O !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_term: got ack0 %b err0 %b want 0 0", M0_ACK_O, M0_ERR_O); end
    to_drive;
    RST_I = 0;
    to_sample;
    n_checks++; if (GNT_O !== 2'b00) begin n_fail++; $display("[TB] FAIL rmid_release: got %b want 00", GNT_O); end
    to_sample;
    n_checks++; if (GNT_O !== 2'b01 || M0_ACK_O !== 1'b1 || M1_ACK_O !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_m0_first: got gnt %b ack0 %b ack1 %b want 01 1 0", GNT_O, M0_ACK_O, M1_ACK_O); end
    go_idle;
  endtask

  initial begin
    RST_I = 1;
    idle_masters;
    test_reset;
    test_m0_write;
    test_tie;
    test_burst_hold;
    test_watchdog;
    test_slave_err;
    test_reset_mid_burst;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got no end of test, required finish within 100000 time units");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
